// File: rtl/flappy_score_bcd.sv
// rtl/flappy_score_bcd.sv - Flappy game 4-digit packed BCD score keeper feeding the display mux
// Optional feature macro: FLAPPY_HIGH_SCORE_EN (high-score register, NEW_HIGH flag, blink on new record)
module flappy_score_bcd #(
    parameter int SATURATE   = 1,
    parameter int BLINK_BITS = 24
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SCORE_INC,
    input  logic        GAME_START,
    input  logic        GAME_OVER,
    input  logic        SHOW_HIGH,
    output logic [15:0] disp_value,
    output logic        NEW_HIGH,
    output logic        SATURATED
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [15:0]           SCORE_MAX = 16'h9999;
    localparam logic [15:0]           SCORE_CLR = 16'h0000;
    localparam logic [15:0]           BLANK_ALL = 16'hFFFF;
    localparam logic [BLINK_BITS-1:0] BLINK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};

    state_t                state_q,    state_d;
    logic [15:0]           score_q,    score_d;
    logic                  inc_prev_q, inc_prev_d;
    logic [BLINK_BITS-1:0] blink_q,    blink_d;
    logic [15:0]           disp_q,     disp_d;
    logic                  sat_q,      sat_d;

    logic                  inc_edge;
    logic [15:0]           score_inc;

`ifdef FLAPPY_HIGH_SCORE_EN
    logic [15:0]           high_q,     high_d;
    logic                  new_high_q, new_high_d;
    logic                  blink_low;
`else
    logic                  unused_show_high;
`endif

    // Increment a packed 4-digit BCD value with a full ripple carry; digits
    // at 9 (or any illegal code) roll to 0 so no digit ever holds A-F.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if ((SATURATE != 0) && (v == SCORE_MAX)) begin
            r = SCORE_MAX;
        end
        return r;
    endfunction

    // Rising-edge detect on the score level, free-running blink counter, next BCD score.
    always_comb begin
        inc_edge   = SCORE_INC & ~inc_prev_q;
        inc_prev_d = SCORE_INC;
        blink_d    = blink_q + BLINK_ONE;
        score_inc  = bcd_inc(score_q);
    end

    // Round FSM: GAME_OVER beats GAME_START in PLAY, GAME_START wins elsewhere;
    // a point scored in the same cycle as GAME_OVER still counts.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE: begin
                score_d = SCORE_CLR;
                if (GAME_START) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (GAME_OVER) begin
                    state_d = ST_OVER;
                    if (inc_edge) begin
                        score_d = score_inc;
                    end
                end else if (GAME_START) begin
                    score_d = SCORE_CLR;
                end else if (inc_edge) begin
                    score_d = score_inc;
                end
            end
            ST_OVER: begin
                if (GAME_START) begin
                    state_d = ST_PLAY;
                    score_d = SCORE_CLR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = SCORE_CLR;
            end
        endcase
    end

`ifdef FLAPPY_HIGH_SCORE_EN
    // Record check on the PLAY->OVER step using the final (possibly just incremented)
    // score; packed BCD orders correctly under a plain unsigned compare.
    always_comb begin
        high_d     = high_q;
        new_high_d = new_high_q;
        if ((state_q == ST_PLAY) && GAME_OVER) begin
            if (score_d > high_q) begin
                high_d     = score_d;
                new_high_d = 1'b1;
            end else begin
                new_high_d = 1'b0;
            end
        end else if (state_d != ST_OVER) begin
            new_high_d = 1'b0;
        end
    end

    assign blink_low = ~blink_q[BLINK_BITS-1];
`else
    assign unused_show_high = SHOW_HIGH;
`endif

    // Display word: all-F blink during a new record's low phase, else high or score.
    always_comb begin
        disp_d = score_q;
`ifdef FLAPPY_HIGH_SCORE_EN
        if ((state_q == ST_OVER) && new_high_q && blink_low) begin
            disp_d = BLANK_ALL;
        end else if (SHOW_HIGH) begin
            disp_d = high_q;
        end
`endif
        sat_d = (SATURATE != 0) && (score_q == SCORE_MAX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            score_q    <= SCORE_CLR;
            inc_prev_q <= 1'b0;
            blink_q    <= '0;
            disp_q     <= SCORE_CLR;
            sat_q      <= 1'b0;
`ifdef FLAPPY_HIGH_SCORE_EN
            high_q     <= SCORE_CLR;
            new_high_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            inc_prev_q <= inc_prev_d;
            blink_q    <= blink_d;
            disp_q     <= disp_d;
            sat_q      <= sat_d;
`ifdef FLAPPY_HIGH_SCORE_EN
            high_q     <= high_d;
            new_high_q <= new_high_d;
`endif
        end
    end

    assign disp_value = disp_q;
    assign SATURATED  = sat_q;
`ifdef FLAPPY_HIGH_SCORE_EN
    assign NEW_HIGH   = new_high_q;
`else
    assign NEW_HIGH   = 1'b0;
`endif

endmodule

// File: tb/tb_flappy_score_bcd.sv
// tb/tb_flappy_score_bcd.sv - scoreboard bench for flappy_score_bcd (saturating and wrapping builds)
module tb_flappy_score_bcd;

    localparam int BB = 4;
`ifdef FLAPPY_HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N, SCORE_INC, GAME_START, GAME_OVER, SHOW_HIGH;
    logic [15:0] disp_s, disp_w;
    logic        nh_s, nh_w, sat_s, sat_w;

    always #5 CLK = ~CLK;

    flappy_score_bcd #(.SATURATE(1), .BLINK_BITS(BB)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .SCORE_INC(SCORE_INC), .GAME_START(GAME_START),
        .GAME_OVER(GAME_OVER), .SHOW_HIGH(SHOW_HIGH),
        .disp_value(disp_s), .NEW_HIGH(nh_s), .SATURATED(sat_s)
    );

    flappy_score_bcd #(.SATURATE(0), .BLINK_BITS(BB)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .SCORE_INC(SCORE_INC), .GAME_START(GAME_START),
        .GAME_OVER(GAME_OVER), .SHOW_HIGH(SHOW_HIGH),
        .disp_value(disp_w), .NEW_HIGH(nh_w), .SATURATED(sat_w)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        nh;
        logic        sat;
    } obs_t;

    typedef struct packed {
        obs_t s;
        obs_t w;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: score/high as plain integers 0..9999, state 0=IDLE 1=PLAY 2=OVER.
    int m_state[2];
    int m_score[2];
    int m_high[2];
    bit m_nh[2];
    bit m_prev;
    int m_blink;
    bit show_v;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int bump(input int v, input bit sat);
        if (sat) return (v >= 9999) ? 9999 : v + 1;
        return (v + 1) % 10000;
    endfunction

    task automatic model_step(input bit r, input bit inc, input bit st, input bit ov, input bit sh);
        exp_t e;
        obs_t o[2];
        bit   rise;
        rise = inc && !m_prev;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                o[i]       = '0;
                m_state[i] = 0;
                m_score[i] = 0;
                m_high[i]  = 0;
                m_nh[i]    = 1'b0;
            end else begin
                if (HS && m_state[i] == 2 && m_nh[i] && m_blink < (1 << (BB - 1)))
                    o[i].d = 16'hFFFF;
                else if (HS && sh)
                    o[i].d = to_bcd(m_high[i]);
                else
                    o[i].d = to_bcd(m_score[i]);
                o[i].sat = (i == 0) && (m_score[i] == 9999);
                case (m_state[i])
                    0: if (st) begin m_state[i] = 1; m_score[i] = 0; end
                    1: begin
                        if (ov) begin
                            if (rise) m_score[i] = bump(m_score[i], i == 0);
                            m_state[i] = 2;
                            if (HS) begin
                                m_nh[i] = m_score[i] > m_high[i];
                                if (m_nh[i]) m_high[i] = m_score[i];
                            end
                        end else if (st) begin
                            m_score[i] = 0;
                        end else if (rise) begin
                            m_score[i] = bump(m_score[i], i == 0);
                        end
                    end
                    default: if (st) begin m_state[i] = 1; m_score[i] = 0; m_nh[i] = 1'b0; end
                endcase
                o[i].nh = m_nh[i];
            end
        end
        m_prev  = r ? inc : 1'b0;
        m_blink = r ? (m_blink + 1) % (1 << BB) : 0;
        e.s = o[0];
        e.w = o[1];
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit r, input bit inc, input bit st, input bit ov);
        @(negedge CLK);
        RST_N      = r;
        SCORE_INC  = inc;
        GAME_START = st;
        GAME_OVER  = ov;
        SHOW_HIGH  = show_v;
        model_step(r, inc, st, ov, show_v);
    endtask

    task automatic edges(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            repeat (hi) tick(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (lo) tick(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every clock the DUTs present a registered output word; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp_sat",  disp_s,          e.s.d);
                check("nh_sat",    {15'd0, nh_s},   {15'd0, e.s.nh});
                check("sat_sat",   {15'd0, sat_s},  {15'd0, e.s.sat});
                check("disp_wrap", disp_w,          e.w.d);
                check("nh_wrap",   {15'd0, nh_w},   {15'd0, e.w.nh});
                check("sat_wrap",  {15'd0, sat_w},  {15'd0, e.w.sat});
            end
        end
    end

    // Stimulus: directed scenarios with randomized pulse shapes, then a random soak.
    initial begin
        RST_N = 1'b0; SCORE_INC = 1'b0; GAME_START = 1'b0; GAME_OVER = 1'b0; SHOW_HIGH = 1'b0;
        show_v = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_score[i] = 0; m_high[i] = 0; m_nh[i] = 1'b0;
        end
        m_prev = 1'b0; m_blink = 0;

        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // carry chain: 10 edges held 5 cycles, then 100 edges with random shapes
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        edges(10, 5, $urandom_range(1, 3));
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) edges(1, $urandom_range(1, 3), $urandom_range(1, 3));
        tick(1'b1, 1'b0, 1'b1, 1'b1);          // start+over in PLAY: over wins

        // round 1: collision at 41 -> 42, edges in OVER ignored
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        edges(41, 1, 1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        edges(5, 2, 2);
        repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // round 2 ties 42, round 3 reaches 107; then view the high score
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        edges(42, 1, 2);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        edges(107, 2, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (40) tick(1'b1, 1'b0, 1'b0, 1'b0);
        show_v = 1'b1;
        repeat (40) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 1'b0, 1'b0);
        show_v = 1'b0;

        // mid-round reset at 23
        edges(23, 1, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // random soak
        for (int k = 0; k < 3000; k++) begin
            bit inc_r;
            inc_r = ($urandom_range(0, 2) == 0) ? ~SCORE_INC : SCORE_INC;
            if ($urandom_range(0, 7) == 0) show_v = ~show_v;
            tick(($urandom_range(0, 399) != 0), inc_r,
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0));
        end
        show_v = 1'b0;

        // saturation vs wrap at 9999
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        edges(9999, 1, 1);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        edges(3, 1, 1);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);
        show_v = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge CLK);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
